// File: rtl/operand_select_stage_pkg.sv
// Shared defaults and forwarding-source encodings for the ALU operand select stage.
package operand_select_stage_pkg;

  localparam int unsigned OpWidthDefault = 32;
  localparam int unsigned NumInDefault   = 4;

  // Forwarding select sources as driven onto select_i by the ID/EX control.
  localparam int unsigned SRC_REG   = 0;
  localparam int unsigned SRC_EXMEM = 1;
  localparam int unsigned SRC_MEMWB = 2;
  localparam int unsigned SRC_IMM   = 3;

endpackage

// File: rtl/operand_select_stage_skid_buffer.sv
// Two-entry valid/ready register: an output register backed by one skid entry so
// ready_o can be registered without losing a beat when the consumer stalls.
module operand_select_stage_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept, xfer;

  assign ready_o = !skid_valid_q;
  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;
  assign accept  = valid_i & ready_o;
  assign xfer    = out_valid_q & ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      // Data registers keep their contents; only occupancy is dropped.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (xfer) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q) begin
      if (accept) begin
        out_data_d  = data_i;
        out_valid_d = 1'b1;
      end
    end else if (accept) begin
      skid_data_d  = data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// N-input ALU operand selector with override path, last-good fallback for bad selects,
// and a registered valid/ready output through a two-entry skid buffer.
module operand_select_stage
  import operand_select_stage_pkg::*;
#(
  parameter int unsigned WIDTH  = OpWidthDefault,
  parameter int unsigned NUM_IN = NumInDefault,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    override_i,
  input  logic [WIDTH-1:0]        override_data_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    sel_err_o
);

  localparam logic [SEL_W:0] NumInW = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] sel, picked;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic             sel_err, sel_err_q, sel_err_d;
  logic             accept;

  assign accept = valid_i & ready_o;

  always_comb begin
    picked = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) picked = data_i[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    sel_err = 1'b0;
    if (override_i) begin
      sel = override_data_i;
    end else if ({1'b0, select_i} < NumInW) begin
      sel = picked;
    end else begin
      // Out-of-range select replays the last good operand rather than holding.
      sel     = last_good_q;
      sel_err = 1'b1;
    end
  end

  always_comb begin
    last_good_d = last_good_q;
    if (accept && !sel_err && !flush_i) last_good_d = sel;
    sel_err_d = accept & sel_err & ~flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_good_q <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      last_good_q <= last_good_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign sel_err_o = sel_err_q;

  operand_select_stage_skid_buffer #(
    .WIDTH(WIDTH)
  ) u_skid_buffer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (sel),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o)
  );

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed and soak stimulus for operand_select_stage (NUM_IN=3) against a
// two-deep FIFO model of the stage, plus hand-computed literal checks.
module tb_operand_select_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned NI = 3;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, override_i, flush_i, ready_i;
  logic [W-1:0]  w [NI];
  logic [NI*W-1:0] data_i;
  logic [1:0]    select_i;
  logic [W-1:0]  override_data_i;
  logic          ready_o, valid_o, sel_err_o;
  logic [W-1:0]  data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  assign data_i = {w[2], w[1], w[0]};

  always #5 clk = ~clk;

  operand_select_stage #(
    .WIDTH (W),
    .NUM_IN(NI)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_i         (data_i),
    .select_i       (select_i),
    .override_i     (override_i),
    .override_data_i(override_data_i),
    .flush_i        (flush_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_o         (data_o),
    .sel_err_o      (sel_err_o)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the stage is a capacity-2 FIFO of selected operands; head is data_o.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_lg;
  bit           m_err, m_zero, m_started;

  initial begin
    m_started = 0;
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("valid_o", W'(valid_o), W'(mq.size() > 0));
        chk("ready_o", W'(ready_o), W'(mq.size() < 2));
        chk("sel_err_o", W'(sel_err_o), W'(m_err));
        if (mq.size() > 0) chk("data_o", data_o, mq[0]);
        else if (m_zero) chk("data_o_rst", data_o, '0);
      end
      // Advance with the inputs that the coming rising edge will sample.
      if (rst_i) begin
        mq.delete();
        m_lg = '0; m_err = 0; m_zero = 1; m_started = 1;
      end else if (m_started) begin
        bit acc, xf, bad;
        logic [W-1:0] s;
        acc = valid_i && (mq.size() < 2);
        xf  = (mq.size() > 0) && ready_i;
        bad = !override_i && (int'(select_i) >= int'(NI));
        s   = override_i ? override_data_i : (bad ? m_lg : w[select_i]);
        if (flush_i) begin
          mq.delete();
          m_err = 0;
        end else begin
          if (xf) void'(mq.pop_front());
          if (acc) begin
            mq.push_back(s);
            m_zero = 0;
            if (!bad) m_lg = s;
          end
          m_err = acc && bad;
        end
      end
    end
  end

  initial begin
    rst_i = 1; valid_i = 0; override_i = 0; flush_i = 0; ready_i = 1;
    select_i = 0; override_data_i = '0;
    for (int i = 0; i < int'(NI); i++) w[i] = 32'h1000_0000 + i;
    step(); step();
    rst_i = 0;
    chk("rst_ready", W'(ready_o), 1);
    chk("rst_valid", W'(valid_o), 0);
    chk("rst_data", data_o, 0);

    // Plain select
    valid_i = 1; select_i = 2; w[2] = 32'hDEAD_BEEF; step();
    chk("t1_valid", W'(valid_o), 1);
    chk("t1_data", data_o, 32'hDEAD_BEEF);
    chk("t1_err", W'(sel_err_o), 0);

    // Override wins and becomes last-good
    override_i = 1; override_data_i = 32'h1F; select_i = 1; step();
    chk("t2_data", data_o, 32'h1F);
    override_i = 0; select_i = 3; step();
    chk("t2_lastgood", data_o, 32'h1F);
    chk("t2_err", W'(sel_err_o), 1);
    valid_i = 0; step();
    chk("t2_err_clr", W'(sel_err_o), 0);

    // Stall with back-to-back A/B
    ready_i = 0; valid_i = 1; select_i = 0; w[0] = 32'h11; step();
    chk("t3_a", data_o, 32'h11);
    w[0] = 32'h22; step();
    chk("t3_full_ready", W'(ready_o), 0);
    chk("t3_hold", data_o, 32'h11);
    valid_i = 0; step();
    chk("t3_hold2", data_o, 32'h11);
    ready_i = 1; step();
    chk("t3_b", data_o, 32'h22);
    chk("t3_b_valid", W'(valid_o), 1);
    step();
    chk("t3_drained", W'(valid_o), 0);

    // Invalid select replays last good
    valid_i = 1; select_i = 0; w[0] = 32'h55; step();
    chk("t4_first", data_o, 32'h55);
    select_i = 3; step();
    chk("t4_second", data_o, 32'h55);
    chk("t4_err", W'(sel_err_o), 1);
    valid_i = 0; step();
    chk("t4_err_once", W'(sel_err_o), 0);

    // Flush with both entries full, then flush with a live accept
    ready_i = 0; valid_i = 1; select_i = 0; w[0] = 32'hA1; step();
    w[0] = 32'hA2; step();
    flush_i = 1; w[0] = 32'hA3; step();
    chk("t5_valid", W'(valid_o), 0);
    chk("t5_ready", W'(ready_o), 1);
    flush_i = 0; w[0] = 32'hB1; step();
    flush_i = 1; select_i = 3; step();
    chk("t5b_valid", W'(valid_o), 0);
    chk("t5b_err", W'(sel_err_o), 0);
    flush_i = 0; valid_i = 0; ready_i = 1; step();
    chk("t5b_gone", W'(valid_o), 0);
    valid_i = 1; select_i = 0; w[0] = 32'hC1; step();
    chk("t5_next", data_o, 32'hC1);

    // Mid-operation reset with skid full
    ready_i = 0; w[0] = 32'hD1; step();
    w[0] = 32'hD2; step();
    rst_i = 1; valid_i = 0; step();
    chk("t6_valid", W'(valid_o), 0);
    chk("t6_data", data_o, 0);
    chk("t6_ready", W'(ready_o), 1);
    rst_i = 0; valid_i = 1; select_i = 3; ready_i = 1; step();
    chk("t6_lastgood0", data_o, 0);
    chk("t6_err", W'(sel_err_o), 1);
    valid_i = 0; step();

    // Soak: random handshake / flush / override mix checked by the model
    for (int c = 0; c < 400; c++) begin
      valid_i         = ($urandom_range(3) != 0);
      ready_i         = ($urandom_range(2) != 0);
      select_i        = 2'($urandom_range(3));
      override_i      = ($urandom_range(4) == 0);
      override_data_i = $urandom;
      flush_i         = ($urandom_range(15) == 0);
      for (int i = 0; i < int'(NI); i++) w[i] = $urandom;
      step();
    end
    valid_i = 0; flush_i = 0; ready_i = 1; step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
